// File: rtl/sic_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sic_io_ctrl
// Description : CPU-to-device I/O controller. Handles TD (test device),
//               RD (read byte) and WD (write byte) requests against up to
//               NUM_DEV attached devices. It checks device readiness with a
//               bounded wait, issues a single read/write strobe, and reports
//               completion with a one-cycle ack plus condition code and error.
//
// Ports       : clk, rst                  clock, sync active-high reset
//               cpu_req/op/dev/wdata      CPU request (sampled in IDLE only)
//               cpu_ack/rdata/cc/err      CPU completion and result
//               dev_sel                   one-hot device select
//               dev_read/write_enable     single-cycle device strobes
//               dev_wdata/dev_rdata       device data bytes
//               dev_ready                 per-device ready
// Revision    : 1.0 - initial release
// ============================================================================
module sic_io_ctrl #(
    parameter int NUM_DEV = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic [1:0]         cpu_op,
    input  logic [7:0]         cpu_dev,
    input  logic [7:0]         cpu_wdata,
    output logic               cpu_ack,
    output logic [7:0]         cpu_rdata,
    output logic [1:0]         cpu_cc,
    output logic               cpu_err,
    output logic [NUM_DEV-1:0] dev_sel,
    output logic               dev_read_enable,
    output logic               dev_write_enable,
    output logic [7:0]         dev_wdata,
    input  logic [7:0]         dev_rdata,
    input  logic [NUM_DEV-1:0] dev_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_check = 2'd1;
    localparam logic [1:0] c_st_xfer  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [1:0] c_op_td  = 2'b00;
    localparam logic [1:0] c_op_rd  = 2'b01;
    localparam logic [1:0] c_op_wd  = 2'b10;
    localparam logic [1:0] c_op_rsv = 2'b11;

    localparam logic [1:0] c_cc_lt = 2'b00;
    localparam logic [1:0] c_cc_eq = 2'b01;
    localparam logic [1:0] c_cc_gt = 2'b10;

    // Last CHECK cycle before giving up on a not-ready device.
    localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);

    // Latched request and control state
    logic [1:0]         r_state;
    logic [1:0]         r_op;
    logic               r_bad;
    logic [7:0]         r_wdata;
    logic [CW-1:0]      r_cnt;

    // Combinational next values
    logic [1:0]         w_state_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_ready;
    logic               w_req_bad;
    logic [NUM_DEV-1:0] w_sel_dec;
    logic               w_ack_nxt;
    logic [7:0]         w_rdata_nxt;
    logic [1:0]         w_cc_nxt;
    logic               w_err_nxt;
    logic [NUM_DEV-1:0] w_sel_nxt;
    logic               w_re_nxt;
    logic               w_we_nxt;
    logic [7:0]         w_wdata_nxt;

    // An invalid request (reserved op or out-of-range device) never selects
    // a device, so the decode below also yields all-zero for it.
    assign w_req_bad = (cpu_op == c_op_rsv) || (32'(cpu_dev) >= NUM_DEV);

    always_comb begin
        w_sel_dec = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            w_sel_dec[i] = (cpu_dev == 8'(i)) && (cpu_op != c_op_rsv);
        end
    end

    // dev_sel is one-hot on the latched device throughout CHECK, so masking
    // dev_ready with it picks the target device's ready bit.
    assign w_ready = |(dev_ready & dev_sel);

    // ------------------------------------------------------------------------
    // State register (also holds latched request and registered outputs)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= c_st_idle;
            r_op             <= c_op_td;
            r_bad            <= 1'b0;
            r_wdata          <= 8'd0;
            r_cnt            <= '0;
            cpu_ack          <= 1'b0;
            cpu_rdata        <= 8'd0;
            cpu_cc           <= c_cc_eq;
            cpu_err          <= 1'b0;
            dev_sel          <= '0;
            dev_read_enable  <= 1'b0;
            dev_write_enable <= 1'b0;
            dev_wdata        <= 8'd0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            if (r_state == c_st_idle && cpu_req) begin
                r_op    <= cpu_op;
                r_bad   <= w_req_bad;
                r_wdata <= cpu_wdata;
            end
            cpu_ack          <= w_ack_nxt;
            cpu_rdata        <= w_rdata_nxt;
            cpu_cc           <= w_cc_nxt;
            cpu_err          <= w_err_nxt;
            dev_sel          <= w_sel_nxt;
            dev_read_enable  <= w_re_nxt;
            dev_write_enable <= w_we_nxt;
            dev_wdata        <= w_wdata_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_idle: begin
                if (cpu_req) begin
                    w_state_nxt = c_st_check;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_check: begin
                if (r_bad || r_op == c_op_td) begin
                    w_state_nxt = c_st_done;
                end else if (w_ready) begin
                    w_state_nxt = c_st_xfer;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_st_done;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_xfer: w_state_nxt = c_st_done;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: values the outputs take in the next state. Select and
    // strobes default to zero so IDLE and DONE never drive a device.
    // ------------------------------------------------------------------------
    always_comb begin
        w_ack_nxt   = 1'b0;
        w_rdata_nxt = cpu_rdata;
        w_cc_nxt    = cpu_cc;
        w_err_nxt   = cpu_err;
        w_sel_nxt   = '0;
        w_re_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
        w_wdata_nxt = dev_wdata;
        case (r_state)
            c_st_idle: begin
                if (cpu_req) begin
                    w_sel_nxt = w_sel_dec;
                end
            end
            c_st_check: begin
                if (r_bad) begin
                    w_ack_nxt = 1'b1;
                    w_err_nxt = 1'b1;
                    w_cc_nxt  = c_cc_gt;
                end else if (r_op == c_op_td) begin
                    w_ack_nxt = 1'b1;
                    w_err_nxt = 1'b0;
                    w_cc_nxt  = w_ready ? c_cc_lt : c_cc_eq;
                end else if (w_ready) begin
                    w_sel_nxt   = dev_sel;
                    w_re_nxt    = (r_op == c_op_rd);
                    w_we_nxt    = (r_op == c_op_wd);
                    w_wdata_nxt = r_wdata;
                end else if (r_cnt == c_cnt_last) begin
                    w_ack_nxt = 1'b1;
                    w_err_nxt = 1'b1;
                    w_cc_nxt  = c_cc_eq;
                end else begin
                    w_sel_nxt = dev_sel;
                end
            end
            c_st_xfer: begin
                // Ready is not re-examined here: the strobe is already out.
                w_ack_nxt = 1'b1;
                w_err_nxt = 1'b0;
                w_cc_nxt  = c_cc_eq;
                if (r_op == c_op_rd) begin
                    w_rdata_nxt = dev_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sic_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sic_io_ctrl
// Description : Directed self-checking bench for sic_io_ctrl (NUM_DEV=4,
//               TIMEOUT=16). Inputs are driven and outputs sampled on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sic_io_ctrl;

    localparam int NUM_DEV = 4;
    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_req;
    logic [1:0]         cpu_op;
    logic [7:0]         cpu_dev;
    logic [7:0]         cpu_wdata;
    logic               cpu_ack;
    logic [7:0]         cpu_rdata;
    logic [1:0]         cpu_cc;
    logic               cpu_err;
    logic [NUM_DEV-1:0] dev_sel;
    logic               dev_read_enable;
    logic               dev_write_enable;
    logic [7:0]         dev_wdata;
    logic [7:0]         dev_rdata;
    logic [NUM_DEV-1:0] dev_ready;

    sic_io_ctrl #(.NUM_DEV(NUM_DEV), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_req          (cpu_req),
        .cpu_op           (cpu_op),
        .cpu_dev          (cpu_dev),
        .cpu_wdata        (cpu_wdata),
        .cpu_ack          (cpu_ack),
        .cpu_rdata        (cpu_rdata),
        .cpu_cc           (cpu_cc),
        .cpu_err          (cpu_err),
        .dev_sel          (dev_sel),
        .dev_read_enable  (dev_read_enable),
        .dev_write_enable (dev_write_enable),
        .dev_wdata        (dev_wdata),
        .dev_rdata        (dev_rdata),
        .dev_ready        (dev_ready)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Per-transaction observations
    int                 lat;
    int                 n_re;
    int                 n_we;
    logic [NUM_DEV-1:0] sel_c1;
    logic [NUM_DEV-1:0] sel_st;
    logic [7:0]         wd_st;
    logic [NUM_DEV-1:0] ack_sel;
    logic [1:0]         ack_cc;
    logic               ack_err;
    logic [7:0]         ack_rdata;
    logic               multihot = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request at the current falling edge and follow it to cpu_ack.
    // Cycle k (k>=1) is the k-th cycle after the request was sampled; ready is
    // presented for cycles rdy_from..rdy_to. Unless keep is set the request
    // drops at cycle drop_at and one extra cycle returns the DUT to IDLE.
    task automatic run_txn(input logic [1:0] op, input logic [7:0] dev,
                           input logic [7:0] wd, input logic [NUM_DEV-1:0] rmask,
                           input int rdy_from, input int rdy_to,
                           input int drop_at, input bit keep, input int max);
        cpu_req   = 1'b1;
        cpu_op    = op;
        cpu_dev   = dev;
        cpu_wdata = wd;
        dev_ready = '0;
        lat = 0; n_re = 0; n_we = 0;
        sel_c1 = '0; sel_st = '0; wd_st = 8'd0;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            lat = k;
            if (k == drop_at && !keep) cpu_req = 1'b0;
            dev_ready = (k >= rdy_from && k <= rdy_to) ? rmask : '0;
            if (k == 1) sel_c1 = dev_sel;
            if ($countones(dev_sel) > 1) multihot = 1'b1;
            if (dev_read_enable)  n_re++;
            if (dev_write_enable) n_we++;
            if (dev_read_enable || dev_write_enable) begin
                sel_st = dev_sel;
                wd_st  = dev_wdata;
            end
            if (cpu_ack) break;
        end
        if (!cpu_ack) lat = max + 1;
        ack_sel   = dev_sel;
        ack_cc    = cpu_cc;
        ack_err   = cpu_err;
        ack_rdata = cpu_rdata;
        if (!keep) begin
            cpu_req   = 1'b0;
            dev_ready = '0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_op = 2'b00; cpu_dev = 8'd0;
        cpu_wdata = 8'd0; dev_rdata = 8'd0; dev_ready = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ack",   cpu_ack, 0);
        chk("rst_err",   cpu_err, 0);
        chk("rst_cc",    cpu_cc, 2'b01);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_sel",   dev_sel, 0);
        chk("rst_re",    dev_read_enable, 0);
        chk("rst_we",    dev_write_enable, 0);
        chk("rst_wdata", dev_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // TD dev=1, ready -> LT
        run_txn(2'b00, 8'd1, 8'h00, 4'b0010, 1, 99, 1, 0, 40);
        chk("td_rdy_lat",   lat, 2);
        chk("td_rdy_selc",  sel_c1, 4'b0010);
        chk("td_rdy_cc",    ack_cc, 2'b00);
        chk("td_rdy_err",   ack_err, 0);
        chk("td_rdy_strb",  n_re + n_we, 0);
        chk("td_rdy_asel",  ack_sel, 0);

        // TD dev=1, not ready -> EQ
        run_txn(2'b00, 8'd1, 8'h00, 4'b0000, 1, 99, 1, 0, 40);
        chk("td_nrdy_lat",  lat, 2);
        chk("td_nrdy_cc",   ack_cc, 2'b01);

        // WD dev=0, 0x41, ready
        run_txn(2'b10, 8'd0, 8'h41, 4'b0001, 1, 99, 1, 0, 40);
        chk("wd_lat",   lat, 3);
        chk("wd_we",    n_we, 1);
        chk("wd_re",    n_re, 0);
        chk("wd_sel",   sel_st, 4'b0001);
        chk("wd_data",  wd_st, 8'h41);
        chk("wd_cc",    ack_cc, 2'b01);
        chk("wd_err",   ack_err, 0);

        // RD dev=2, ready on the third CHECK cycle
        dev_rdata = 8'h5A;
        run_txn(2'b01, 8'd2, 8'h00, 4'b0100, 3, 99, 1, 0, 40);
        chk("rd_lat",   lat, 5);
        chk("rd_re",    n_re, 1);
        chk("rd_we",    n_we, 0);
        chk("rd_sel",   sel_st, 4'b0100);
        chk("rd_rdata", ack_rdata, 8'h5A);
        chk("rd_err",   ack_err, 0);
        chk("rd_cc",    ack_cc, 2'b01);

        // RD dev=3, never ready -> timeout; cpu_rdata keeps the last good byte
        dev_rdata = 8'hC3;
        run_txn(2'b01, 8'd3, 8'h00, 4'b1000, 99, 99, 1, 0, 40);
        chk("to_lat",   lat, TIMEOUT + 1);
        chk("to_err",   ack_err, 1);
        chk("to_cc",    ack_cc, 2'b01);
        chk("to_strb",  n_re + n_we, 0);
        chk("to_rdata", ack_rdata, 8'h5A);

        // Out-of-range device
        run_txn(2'b00, 8'd5, 8'h00, 4'b1111, 1, 99, 1, 0, 40);
        chk("bad_dev_lat",  lat, 2);
        chk("bad_dev_err",  ack_err, 1);
        chk("bad_dev_cc",   ack_cc, 2'b10);
        chk("bad_dev_sel",  sel_c1, 0);

        // Reserved op on a valid, ready device
        run_txn(2'b11, 8'd0, 8'h00, 4'b1111, 1, 99, 1, 0, 40);
        chk("bad_op_lat",   lat, 2);
        chk("bad_op_err",   ack_err, 1);
        chk("bad_op_cc",    ack_cc, 2'b10);
        chk("bad_op_sel",   sel_c1, 0);
        chk("bad_op_strb",  n_re + n_we, 0);

        // WD dev=1 with ready dropping during XFER: strobe still issued
        run_txn(2'b10, 8'd1, 8'h9C, 4'b0010, 1, 1, 1, 0, 40);
        chk("drop_lat",  lat, 3);
        chk("drop_we",   n_we, 1);
        chk("drop_data", wd_st, 8'h9C);
        chk("drop_err",  ack_err, 0);

        // Back-to-back TD with request held through DONE
        run_txn(2'b00, 8'd2, 8'h00, 4'b0100, 1, 99, 1, 1, 40);
        chk("b2b1_lat", lat, 2);
        chk("b2b1_cc",  ack_cc, 2'b00);
        run_txn(2'b00, 8'd3, 8'h00, 4'b0000, 1, 99, 2, 0, 40);
        chk("b2b2_lat", lat, 3);
        chk("b2b2_cc",  ack_cc, 2'b01);

        // Reset during XFER of an RD
        dev_rdata = 8'hE7;
        cpu_req = 1'b1; cpu_op = 2'b01; cpu_dev = 8'd0; dev_ready = 4'b0001;
        @(negedge clk);                 // CHECK
        cpu_req = 1'b0;
        @(negedge clk);                 // XFER
        chk("rx_re_pre", dev_read_enable, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rx_ack",   cpu_ack, 0);
        chk("rx_re",    dev_read_enable, 0);
        chk("rx_we",    dev_write_enable, 0);
        chk("rx_rdata", cpu_rdata, 0);
        chk("rx_sel",   dev_sel, 0);
        chk("rx_cc",    cpu_cc, 2'b01);
        chk("rx_wdata", dev_wdata, 0);
        rst = 1'b0;
        dev_ready = '0;
        @(negedge clk);
        chk("rx_ack_p1", cpu_ack, 0);
        @(negedge clk);
        chk("rx_ack_p2", cpu_ack, 0);

        chk("sel_onehot", multihot, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
